shadow_err_alert: RTL
=====================

SHADOW_ERR_ALERT -- requirements
Module: shadow_err_alert

Interface
REQ-001 The block SHALL have parameter NumRegs, default 8, giving the number of shadowed registers monitored (1..32).
REQ-002 The block SHALL have parameter AckTimeout, default 16, giving the maximum cycles to wait for an alert ack (2..255).
REQ-003 The block SHALL have port clk_i, input, 1, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_i, input, 1, a synchronous active-high reset.
REQ-005 The block SHALL have port err_update_i, input, NumRegs, the per-register update-error flags from shadowed registers.
REQ-006 The block SHALL have port err_storage_i, input, NumRegs, the per-register storage-error flags from shadowed registers.
REQ-007 The block SHALL have port clr_recov_i, input, NumRegs, a write-1-to-clear strobe for recov_status_o.
REQ-008 The block SHALL have port recov_ack_i, input, 1, the alert receiver acknowledge for the recoverable alert.
REQ-009 The block SHALL have port recov_alert_o, output, 1, the recoverable alert request (level).
REQ-010 The block SHALL have port fatal_alert_o, output, 1, the fatal alert (level, sticky).
REQ-011 The block SHALL have port recov_status_o, output, NumRegs, the sticky update-error status.
REQ-012 The block SHALL have port fatal_status_o, output, NumRegs, the sticky storage-error status.
REQ-013 The block SHALL have port err_cnt_o, output, 8, a saturating count of update-error events.
REQ-014 The block SHALL have port ack_timeout_o, output, 1, a sticky flag set when the ack times out.

Function
REQ-015 recov_status_o[i] SHALL set on the cycle after err_update_i[i]=1; clr_recov_i[i]=1 SHALL clear it; when both occur in the same cycle, set SHALL win.
REQ-016 fatal_status_o[i] SHALL set on the cycle after err_storage_i[i]=1 and SHALL clear only by reset.
REQ-017 fatal_alert_o SHALL equal OR-reduce(fatal_status_o), with 1-cycle latency from err_storage_i, and SHALL stay high until reset.
REQ-018 err_cnt_o SHALL increment by 1 per cycle in which any err_update_i bit is 1, and SHALL saturate at 255 without wrapping.
REQ-019 The handshake FSM SHALL have states Idle, Req, Hold; recov_alert_o SHALL be 1 only in Req.
REQ-020 In Idle, a trigger (any err_update_i bit = 1, or pending = 1) SHALL move the FSM to Req on the next cycle and clear pending.
REQ-021 In Req, recov_ack_i=1 SHALL move the FSM to Hold; in Hold, recov_ack_i=0 SHALL move it to Idle.
REQ-022 A trigger arriving while in Req or Hold SHALL set a 1-bit pending flag, so that one further Req is issued after returning to Idle; multiple triggers SHALL collapse into one.
REQ-023 A timeout counter SHALL count cycles spent in Req; on reaching AckTimeout without ack, it SHALL set ack_timeout_o and move the FSM to Idle (pending retained). The counter SHALL clear on leaving Req.
REQ-024 recov_ack_i while in Idle SHALL be ignored.
REQ-025 Storage errors SHALL NOT trigger the recoverable FSM.

Reset
REQ-026 With rst_i=1 at a clock edge, the block SHALL set the FSM to Idle and clear pending, the counters, all status bits, recov_alert_o, fatal_alert_o and ack_timeout_o to 0; reset SHALL override all inputs in that cycle, including mid-handshake.

Configuration
REQ-027 With macro SHADOW_ERR_ALERT_TEST_EN defined, the block SHALL add input alert_test_i (1 bit): a pulse SHALL act as a recoverable trigger and force fatal_alert_o high for that one following cycle only, without changing any status or counter.
REQ-028 Without SHADOW_ERR_ALERT_TEST_EN, the block SHALL NOT have the port, and the behaviour SHALL be as in REQ-015 to REQ-025.

Structure
REQ-029 Package shadow_err_pkg SHALL hold the alert_fsm_e enum (Idle, Req, Hold), the ErrCntW=8 constant, and the default AckTimeout constant.
REQ-030 The handshake FSM, pending flag and timeout counter SHALL be one sub-module, shadow_alert_hs, instantiated once.

Verification
REQ-031 Bench: err_update_i=8'h04 for 1 cycle -> next cycle recov_status_o=8'h04, err_cnt_o=1, recov_alert_o=1; ack high -> alert 0; ack low -> Idle.
REQ-032 Bench: err_storage_i=8'h80 for 1 cycle -> next cycle fatal_status_o=8'h80 and fatal_alert_o=1; clr_recov_i=8'hFF has no effect on these; rst_i clears them.
REQ-033 Bench: hold recov_ack_i=0 for 16 cycles in Req -> ack_timeout_o=1, recov_alert_o=0; a second error during Req -> a second Req is issued after Hold/Idle.
REQ-034 Bench: err_update_i=1 for 300 consecutive cycles -> err_cnt_o=255 held; clr_recov_i[0] together with err_update_i[0] -> bit stays 1.
REQ-035 Bench: assert rst_i while the FSM is in Hold -> all outputs 0 next cycle; with SHADOW_ERR_ALERT_TEST_EN, an alert_test_i pulse -> a 1-cycle fatal_alert_o and a Req, with status unchanged.

Source files
------------

// File: rtl/shadow_err_pkg.sv
// Shared types and constants for the shadowed-register error alert block.
// Optional build macro: SHADOW_ERR_ALERT_TEST_EN (adds alert_test_i to the top).
package shadow_err_pkg;

  // Recoverable alert handshake states
  typedef enum logic [1:0] {
    AlertIdle = 2'b00,
    AlertReq  = 2'b01,
    AlertHold = 2'b10
  } alert_fsm_e;

  // Width of the saturating update-error event counter
  localparam int unsigned ErrCntW = 8;

  // Default number of cycles to wait for the alert receiver acknowledge
  localparam int unsigned AckTimeoutDefault = 16;

  // Width of the ack timeout counter (AckTimeout is at most 255)
  localparam int unsigned AckCntW = 8;

endpackage : shadow_err_pkg

// File: rtl/shadow_alert_hs.sv
// Recoverable alert request/ack handshake with a 1-bit pending flag that
// collapses triggers arriving mid-handshake, and an ack timeout.
// Optional build macro: SHADOW_ERR_ALERT_TEST_EN (not used directly here).
module shadow_alert_hs
  import shadow_err_pkg::*;
#(
  parameter int unsigned AckTimeout = AckTimeoutDefault
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic trigger_i,
  input  logic ack_i,
  output logic alert_o,
  output logic timeout_o
);

  localparam logic [AckCntW-1:0] AckCntLast = AckCntW'(AckTimeout - 1);

  alert_fsm_e         state_q, state_d;
  logic               pending_q, pending_d;
  logic [AckCntW-1:0] ack_cnt_q, ack_cnt_d;
  logic               timeout_q, timeout_d;
  logic               alert_q, alert_d;

  // Next-state logic: handshake progression, pending capture and timeout
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    ack_cnt_d = {AckCntW{1'b0}};
    timeout_d = timeout_q;
    case (state_q)
      AlertIdle: begin
        // An ack seen here is stray and deliberately ignored
        if (trigger_i || pending_q) begin
          state_d   = AlertReq;
          pending_d = 1'b0;
        end else begin
          state_d   = AlertIdle;
        end
      end
      AlertReq: begin
        pending_d = pending_q | trigger_i;
        if (ack_i) begin
          state_d = AlertHold;
        end else if (ack_cnt_q == AckCntLast) begin
          // Give up on the receiver; any pending trigger survives
          state_d   = AlertIdle;
          timeout_d = 1'b1;
        end else begin
          state_d   = AlertReq;
          ack_cnt_d = ack_cnt_q + {{(AckCntW-1){1'b0}}, 1'b1};
        end
      end
      AlertHold: begin
        pending_d = pending_q | trigger_i;
        if (!ack_i) begin
          state_d = AlertIdle;
        end else begin
          state_d = AlertHold;
        end
      end
      default: begin
        state_d   = AlertIdle;
        pending_d = 1'b0;
      end
    endcase
    alert_d = (state_d == AlertReq);
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= AlertIdle;
      pending_q <= 1'b0;
      ack_cnt_q <= {AckCntW{1'b0}};
      timeout_q <= 1'b0;
      alert_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      ack_cnt_q <= ack_cnt_d;
      timeout_q <= timeout_d;
      alert_q   <= alert_d;
    end
  end

  assign alert_o   = alert_q;
  assign timeout_o = timeout_q;

endmodule : shadow_alert_hs

// File: rtl/shadow_err_alert.sv
// Collects update/storage error flags from shadowed registers into sticky
// status, a saturating error counter, a sticky fatal alert and a recoverable
// alert handshake.
// Optional build macro: SHADOW_ERR_ALERT_TEST_EN adds alert_test_i, which
// fires a recoverable request plus a one-cycle fatal alert pulse.
module shadow_err_alert
  import shadow_err_pkg::*;
#(
  parameter int unsigned NumRegs    = 8,
  parameter int unsigned AckTimeout = AckTimeoutDefault
) (
  input  logic               clk_i,
  input  logic               rst_i,
`ifdef SHADOW_ERR_ALERT_TEST_EN
  input  logic               alert_test_i,
`endif
  input  logic [NumRegs-1:0] err_update_i,
  input  logic [NumRegs-1:0] err_storage_i,
  input  logic [NumRegs-1:0] clr_recov_i,
  input  logic               recov_ack_i,
  output logic               recov_alert_o,
  output logic               fatal_alert_o,
  output logic [NumRegs-1:0] recov_status_o,
  output logic [NumRegs-1:0] fatal_status_o,
  output logic [ErrCntW-1:0] err_cnt_o,
  output logic               ack_timeout_o
);

  localparam logic [ErrCntW-1:0] ErrCntMax = {ErrCntW{1'b1}};

  logic               test_s;
  logic               any_update_s;
  logic               trigger_s;
  logic [NumRegs-1:0] recov_status_q, recov_status_d;
  logic [NumRegs-1:0] fatal_status_q, fatal_status_d;
  logic               fatal_alert_q, fatal_alert_d;
  logic [ErrCntW-1:0] err_cnt_q, err_cnt_d;

`ifdef SHADOW_ERR_ALERT_TEST_EN
  assign test_s = alert_test_i;
`else
  assign test_s = 1'b0;
`endif

  assign any_update_s = |err_update_i;
  // Storage errors are fatal only; they never start a recoverable request
  assign trigger_s    = any_update_s | test_s;

  // Sticky status, fatal alert and saturating counter next-state
  always_comb begin
    // A new error outranks a clear strobe on the same bit
    recov_status_d = (recov_status_q & ~clr_recov_i) | err_update_i;
    fatal_status_d = fatal_status_q | err_storage_i;
    // Test pulse only lifts the alert output, never the sticky status
    fatal_alert_d  = (|fatal_status_d) | test_s;
    if (any_update_s && (err_cnt_q != ErrCntMax)) begin
      err_cnt_d = err_cnt_q + {{(ErrCntW-1){1'b0}}, 1'b1};
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // Status and counter registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      recov_status_q <= {NumRegs{1'b0}};
      fatal_status_q <= {NumRegs{1'b0}};
      fatal_alert_q  <= 1'b0;
      err_cnt_q      <= {ErrCntW{1'b0}};
    end else begin
      recov_status_q <= recov_status_d;
      fatal_status_q <= fatal_status_d;
      fatal_alert_q  <= fatal_alert_d;
      err_cnt_q      <= err_cnt_d;
    end
  end

  shadow_alert_hs #(
    .AckTimeout (AckTimeout)
  ) u_alert_hs (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .trigger_i (trigger_s),
    .ack_i     (recov_ack_i),
    .alert_o   (recov_alert_o),
    .timeout_o (ack_timeout_o)
  );

  assign fatal_alert_o  = fatal_alert_q;
  assign recov_status_o = recov_status_q;
  assign fatal_status_o = fatal_status_q;
  assign err_cnt_o      = err_cnt_q;

endmodule : shadow_err_alert
